// File: rtl/c_gather_arbiter_pkg.sv
// Shared helpers for the gather arbiter slice: width calculation used for port indices.
package c_gather_arbiter_pkg;

    // Ceiling log2, never less than 1 so single-port builds still get a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/c_gather_arbiter_gather.sv
// Fixed-mask bit gather: the k-th set mask bit's data bit lands at out index k, rest zero.
module c_gather #(
    parameter int in_width = 32,
    parameter int out_width = 32,
    parameter logic [in_width-1:0] mask = {in_width{1'b1}}
) (
    input  logic [in_width-1:0]  data_in,
    output logic [out_width-1:0] data_out
);

    // Number of set mask bits strictly below idx, i.e. the destination slot of bit idx.
    function automatic int rank(input int idx);
        int cnt;
        cnt = 0;
        for (int i = 0; i < idx; i++) begin
            if (mask[i]) cnt++;
        end
        return cnt;
    endfunction

    for (genvar i = 0; i < in_width; i++) begin : g_bit
        if (mask[i] && (rank(i) < out_width)) begin : g_sel
            assign data_out[rank(i)] = data_in[i];
        end
    end

    for (genvar k = 0; k < out_width; k++) begin : g_pad
        if (k >= rank(in_width)) begin : g_zero
            assign data_out[k] = 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^(data_in & ~mask);

endmodule

// File: rtl/c_gather_arbiter_rr_select.sv
// Round-robin pick: first asserted request scanning cyclically upward from ptr.
module c_rr_select #(
    parameter int num_ports = 4,
    parameter int idx_width = 2
) (
    input  logic [num_ports-1:0] req,
    input  logic [idx_width-1:0] ptr,
    output logic [num_ports-1:0] grant,
    output logic [idx_width-1:0] idx
);

    logic [num_ports-1:0] rot;
    logic [idx_width-1:0] off;
    logic [idx_width:0]   sum;

    always_comb begin
        rot = num_ports'({req, req} >> ptr);
        off = '0;
        for (int i = num_ports - 1; i >= 0; i--) begin
            if (rot[i]) off = i[idx_width-1:0];
        end
        // Undo the rotation; ptr + off stays below 2*num_ports, so one subtract wraps it.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (idx_width + 1)'(num_ports)) sum = sum - (idx_width + 1)'(num_ports);
        idx   = sum[idx_width-1:0];
        grant = (|req) ? (num_ports'(1) << idx) : '0;
    end

endmodule

// File: rtl/c_gather_arbiter.sv
// Round-robin arbiter feeding one registered gather stage; the winner's word is compressed by its port mask.
module c_gather_arbiter
    import c_gather_arbiter_pkg::*;
#(
    parameter int num_ports = 4,
    parameter int in_width = 32,
    parameter logic [num_ports*in_width-1:0] masks = {num_ports*in_width{1'b1}},
    parameter int out_width = in_width,
    localparam int port_idx_width = clog2(num_ports)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_ports-1:0]          req_valid,
    input  logic [num_ports*in_width-1:0] req_data,
    output logic [num_ports-1:0]          req_ready,
    output logic                          out_valid,
    output logic [out_width-1:0]          out_data,
    output logic [port_idx_width-1:0]     out_port,
    input  logic                          out_ready
);

    function automatic int max_popcount();
        int best;
        int cnt;
        best = 0;
        for (int p = 0; p < num_ports; p++) begin
            cnt = 0;
            for (int b = 0; b < in_width; b++) begin
                if (masks[p*in_width + b]) cnt++;
            end
            if (cnt > best) best = cnt;
        end
        return best;
    endfunction

    if (max_popcount() > out_width) begin : g_width_check
        $error("c_gather_arbiter: out_width %0d is below max mask popcount %0d",
               out_width, max_popcount());
    end

    logic [out_width-1:0]      gathered [num_ports];
    logic [num_ports-1:0]      grant;
    logic [port_idx_width-1:0] grant_idx;
    logic [port_idx_width-1:0] ptr;
    logic                      load;
    logic                      xfer;

    for (genvar p = 0; p < num_ports; p++) begin : g_port
        c_gather #(
            .in_width (in_width),
            .out_width(out_width),
            .mask     (masks[p*in_width +: in_width])
        ) u_gather (
            .data_in (req_data[p*in_width +: in_width]),
            .data_out(gathered[p])
        );
    end

    c_rr_select #(
        .num_ports(num_ports),
        .idx_width(port_idx_width)
    ) u_rr_select (
        .req  (req_valid),
        .ptr  (ptr),
        .grant(grant),
        .idx  (grant_idx)
    );

    // Handshake: a word moves on any edge where valid && ready on that side; the producer
    // may withdraw valid without a transfer, and out_data/out_port are stable while
    // out_valid && !out_ready. req_ready is a pure function of req_valid, ptr, out_valid,
    // out_ready and reset, never of req_data.
    assign load      = !out_valid || out_ready;
    assign req_ready = (load && !reset) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gathered[grant_idx];
                out_port  <= grant_idx;
                ptr       <= (grant_idx == port_idx_width'(num_ports - 1)) ? '0
                                                                           : grant_idx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c_gather_arbiter.sv
// Directed bench for c_gather_arbiter: 4 ports, 8-bit words, masks {0..3},{1,3,5,7},{7},{0..7}.
module tb_c_gather_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        out_ready;

    int total;
    int bad;

    logic [7:0] exp_full [4];

    c_gather_arbiter #(
        .num_ports(4),
        .in_width (8),
        .masks    ({8'hFF, 8'h80, 8'hAA, 8'h0F}),
        .out_width(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_port (out_port),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] port, input logic [7:0] data);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, "_port"}, {30'd0, out_port}, {30'd0, port});
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, data});
    endtask

    task automatic check_ready(input string tag, input logic [3:0] exp_ready);
        #1;
        check(tag, {28'd0, req_ready}, {28'd0, exp_ready});
    endtask

    initial begin
        total = 0;
        bad = 0;
        // Gathered values of the data words used in the round-robin run, per port.
        exp_full[0] = 8'h0C;  // 0x3C masked by bits 0..3
        exp_full[1] = 8'h0F;  // 0xFF, bits 1,3,5,7
        exp_full[2] = 8'h01;  // 0x80, bit 7
        exp_full[3] = 8'h5A;  // 0x5A, all bits

        reset = 1'b1;
        req_valid = 4'h0;
        req_data = 32'h0;
        out_ready = 1'b1;
        cyc();
        cyc();

        // Reset: no grants even with requests pending, outputs cleared.
        req_valid = 4'hF;
        check_ready("rst_ready", 4'h0);
        cyc();
        check_out("rst_state", 1'b0, 2'd0, 8'h00);

        // Single port1 request; bits 1,3,5,7 of 0x55 are all zero.
        reset = 1'b0;
        req_valid = 4'b0010;
        req_data[15:8] = 8'h55;
        check_ready("t1_ready", 4'b0010);
        cyc();
        check_out("t1_out", 1'b1, 2'd1, 8'h00);

        // Port1 again with 0xA6: bits1=1,3=0,5=1,7=1 -> 4'b1101.
        req_data[15:8] = 8'hA6;
        check_ready("t1b_ready", 4'b0010);
        cyc();
        check_out("t1b_out", 1'b1, 2'd1, 8'h0D);

        // All ports valid: pointer is at 2, so grants rotate 2,3,0,1,...
        req_valid = 4'hF;
        req_data = {8'h5A, 8'h80, 8'hFF, 8'h3C};
        for (int i = 0; i < 8; i++) begin
            check_ready("t2_ready", 4'b0001 << ((2 + i) % 4));
            cyc();
            check_out("t2_out", 1'b1, 2'((2 + i) % 4), exp_full[(2 + i) % 4]);
        end

        // Port2 then port3, consecutive grants.
        req_valid = 4'b1100;
        req_data[23:16] = 8'h01;
        req_data[31:24] = 8'hA0;
        check_ready("t3_ready2", 4'b0100);
        cyc();
        check_out("t3_out2", 1'b1, 2'd2, 8'h00);
        check_ready("t3_ready3", 4'b1000);
        cyc();
        check_out("t3_out3", 1'b1, 2'd3, 8'hA0);

        // Stall with all valid: nothing granted, output held.
        req_valid = 4'hF;
        req_data = {8'h5A, 8'h80, 8'hFF, 8'h3C};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_ready("t4_stall_ready", 4'h0);
            cyc();
            check_out("t4_stall_out", 1'b1, 2'd3, 8'hA0);
        end
        out_ready = 1'b1;
        check_ready("t4_release_ready", 4'b0001);
        cyc();
        check_out("t4_release_out", 1'b1, 2'd0, 8'h0C);

        // Move pointer to 3 via a port2 grant, then reset during a stall.
        req_valid = 4'b0100;
        check_ready("t5_setup_ready", 4'b0100);
        cyc();
        check_out("t5_setup_out", 1'b1, 2'd2, 8'h01);
        out_ready = 1'b0;
        reset = 1'b1;
        req_valid = 4'hF;
        check_ready("t5_rst_ready", 4'h0);
        cyc();
        check_out("t5_rst_out", 1'b0, 2'd0, 8'h00);
        reset = 1'b0;
        out_ready = 1'b1;
        check_ready("t5_first_ready", 4'b0001);
        cyc();
        check_out("t5_first_out", 1'b1, 2'd0, 8'h0C);

        // Drain: out_valid falls, data/port hold.
        req_valid = 4'h0;
        check_ready("t6_idle_ready", 4'h0);
        cyc();
        check_out("t6_drain", 1'b0, 2'd0, 8'h0C);
        cyc();
        check_out("t6_idle", 1'b0, 2'd0, 8'h0C);

        // Port3 only, then port0 only; the 3->0 wrap then gives port0 priority.
        req_valid = 4'b1000;
        check_ready("t6_p3_ready", 4'b1000);
        cyc();
        check_out("t6_p3_out", 1'b1, 2'd3, 8'h5A);
        req_valid = 4'b0001;
        check_ready("t6_p0_ready", 4'b0001);
        cyc();
        check_out("t6_p0_out", 1'b1, 2'd0, 8'h0C);
        req_valid = 4'b1010;
        check_ready("t6_after_wrap_ready", 4'b0010);
        cyc();
        check_out("t6_after_wrap_out", 1'b1, 2'd1, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
